// File: rtl/beep_gen.sv
// beep_gen: queued beep requests become timed square-wave tone bursts on o_buzz.
// Optional `BEEP_ABORT_EN adds i_abort, which flushes the queue and silences at once.
module beep_gen #(
    parameter int F_COUNT  = 100_000,
    parameter int TONE_DIV = 25_000,
    parameter int BEEP_MS  = 100,
    parameter int GAP_MS   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_trig,
    input  logic [2:0] i_cnt,
`ifdef BEEP_ABORT_EN
    input  logic       i_abort,
`endif
    output logic       o_buzz,
    output logic       o_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BEEP = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int MS_MAX = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;
    localparam int PRE_W  = (F_COUNT  > 1) ? $clog2(F_COUNT)  : 1;
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int MS_W   = (MS_MAX   > 1) ? $clog2(MS_MAX)   : 1;

    logic [1:0]        state_q, state_d;
    logic [2:0]        pend_q, pend_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tone_q, tone_d;

    logic              dec;
    logic              tick;
    logic [2:0]        add;
    logic [3:0]        sum;

    assign tick = (pre_q == PRE_W'(F_COUNT - 1));
    assign add  = i_trig ? i_cnt : 3'd0;

    always_comb begin
        state_d    = state_q;
        pre_d      = tick ? '0 : pre_q + PRE_W'(1);
        ms_d       = tick ? ms_q + MS_W'(1) : ms_q;
        tone_cnt_d = '0;
        tone_d     = 1'b0;
        dec        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pre_d = '0;
                ms_d  = '0;
                if (pend_q != 3'd0) begin
                    dec     = 1'b1;
                    state_d = ST_BEEP;
                    tone_d  = 1'b1;
                end
            end
            ST_BEEP: begin
                if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
                    tone_cnt_d = '0;
                    tone_d     = ~tone_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + TONE_W'(1);
                    tone_d     = tone_q;
                end
                if (tick && ms_q == MS_W'(BEEP_MS - 1)) begin
                    state_d    = ST_GAP;
                    pre_d      = '0;
                    ms_d       = '0;
                    tone_cnt_d = '0;
                    tone_d     = 1'b0;
                end
            end
            ST_GAP: begin
                if (tick && ms_q == MS_W'(GAP_MS - 1)) begin
                    pre_d = '0;
                    ms_d  = '0;
                    if (pend_q != 3'd0) begin
                        dec     = 1'b1;
                        state_d = ST_BEEP;
                        tone_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pre_d   = '0;
                ms_d    = '0;
            end
        endcase

        // dec only fires with pend_q != 0, so the 4-bit sum never underflows
        sum    = {1'b0, pend_q} - {3'b000, dec} + {1'b0, add};
        pend_d = (sum > 4'd7) ? 3'd7 : sum[2:0];

`ifdef BEEP_ABORT_EN
        if (i_abort) begin
            state_d    = ST_IDLE;
            pend_d     = '0;
            pre_d      = '0;
            ms_d       = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            pre_q      <= '0;
            ms_q       <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pre_q      <= pre_d;
            ms_q       <= ms_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
        end
    end

    assign o_buzz = (state_q == ST_BEEP) & tone_q;
    assign o_busy = (state_q != ST_IDLE) | (pend_q != 3'd0);

endmodule

// File: tb/tb_beep_gen.sv
// Scoreboard bench for beep_gen: per-cycle expected o_buzz/o_busy queued by stimulus, checked by a monitor.
module tb_beep_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_trig;
    logic [2:0] i_cnt;
    logic       i_abort;
    logic       o_buzz;
    logic       o_busy;

    typedef struct {
        int unsigned cyc;
        int          sc;
        logic        buzz;
        logic        busy;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          sc = 0;
    bit          done = 1'b0;

    beep_gen #(
        .F_COUNT (10),
        .TONE_DIV(3),
        .BEEP_MS (4),
        .GAP_MS  (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_trig (i_trig),
        .i_cnt  (i_cnt),
`ifdef BEEP_ABORT_EN
        .i_abort(i_abort),
`endif
        .o_buzz (o_buzz),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs set here are sampled at the next edge; the expectation is for the output after that edge.
    task automatic step(input logic tr, input logic [2:0] cnt, input logic r, input logic ab,
                        input logic eb, input logic ey);
        exp_t e;
        i_trig  = tr;
        i_cnt   = cnt;
        rst     = r;
        i_abort = ab;
        e.cyc   = cyc + 1;
        e.sc    = sc;
        e.buzz  = eb;
        e.busy  = ey;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic burst(input int len, input bit tr_en, input int tr_at, input logic [2:0] tr_cnt);
        for (int i = 0; i < len; i++)
            step(tr_en && (i == tr_at), tr_cnt, 1'b0, 1'b0, ((i / 3) % 2) == 0, 1'b1);
    endtask

    task automatic gap(input int len);
        for (int i = 0; i < len; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic trig(input logic [2:0] n);
        step(1'b1, n, 1'b0, 1'b0, 1'b0, n != 3'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL stale sc%0d cyc=%0d expectation never compared (now cyc=%0d)", e.sc, e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                checks++;
                if (o_buzz !== e.buzz || o_busy !== e.busy) begin
                    failures++;
                    $display("FAIL sc%0d cyc=%0d o_buzz=%b o_busy=%b expected o_buzz=%b o_busy=%b",
                             e.sc, cyc, o_buzz, o_busy, e.buzz, e.busy);
                end
            end
            if (done && q.size() == 0) break;
        end
    end

    initial begin
        rst = 1'b1; i_trig = 1'b0; i_cnt = 3'd0; i_abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        sc = 1;  // reset values, then quiet idle
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(100);

        sc = 2;  // single beep
        idle(4);
        trig(3'd1);
        burst(40, 1'b0, 0, 3'd0);
        gap(20);
        idle(10);

        sc = 3;  // three queued beeps, busy continuous
        trig(3'd3);
        for (int b = 0; b < 3; b++) begin burst(40, 1'b0, 0, 3'd0); gap(20); end
        idle(10);

        sc = 4;  // 5 then 5 again during the first beep: saturates, 8 bursts
        trig(3'd5);
        burst(40, 1'b1, 10, 3'd5);
        gap(20);
        for (int b = 0; b < 7; b++) begin burst(40, 1'b0, 0, 3'd0); gap(20); end
        idle(10);

        sc = 5;  // zero-count request is ignored
        trig(3'd0);
        idle(20);

        sc = 6;  // trigger on the edge that ends a gap while one beep is still pending
        trig(3'd2);
        burst(40, 1'b0, 0, 3'd0);
        gap(20);
        burst(40, 1'b1, 0, 3'd2);
        gap(20);
        for (int b = 0; b < 2; b++) begin burst(40, 1'b0, 0, 3'd0); gap(20); end
        idle(10);

        sc = 7;  // reset mid-beep clears everything
        trig(3'd3);
        burst(15, 1'b0, 0, 3'd0);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(80);

`ifdef BEEP_ABORT_EN
        sc = 8;  // abort mid-gap with 4 pending, simultaneous trigger dropped
        trig(3'd5);
        burst(40, 1'b0, 0, 3'd0);
        gap(10);
        step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(80);
`endif

        done = 1'b1;
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
